// File: rtl/sqrt_arb.sv
// sqrt_arb: round-robin arbiter that shares one pipelined, in-order sqrt unit
// among N_REQ requesters and routes each result back to the requester that
// issued it.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   en              grant enable; low blocks new grants, results still return
//   req_vld/req_x   per-requester request valid and 32-bit radicand
//   req_rdy         per-requester accept (combinational, one-hot or zero)
//   sq_vld_in/sq_x  issue strobe and radicand to the sqrt unit
//   sq_vld_out/sq_y result strobe and 16-bit root from the sqrt unit
//   rsp_vld/rsp_y   per-requester result pulse and shared result bus
//   outst           requests issued whose results have not returned yet
//   err             sticky flag: a result arrived with nothing outstanding
module sqrt_arb #(
  parameter int N_REQ     = 4,
  parameter int MAX_OUTST = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N_REQ-1:0]             req_vld,
  input  logic [N_REQ*32-1:0]          req_x,
  output logic [N_REQ-1:0]             req_rdy,
  output logic                         sq_vld_in,
  output logic [31:0]                  sq_x,
  input  logic                         sq_vld_out,
  input  logic [15:0]                  sq_y,
  output logic [N_REQ-1:0]             rsp_vld,
  output logic [15:0]                  rsp_y,
  output logic [$clog2(MAX_OUTST):0]   outst,
  output logic                         err
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int OUT_W = PTR_W + 1;
  localparam int ID_W  = $clog2(N_REQ);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             grant_any;
  logic             can_grant;
  logic             accept;
  logic             ret_ok;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ID_W-1:0]  id_mem [MAX_OUTST];

  // rst_n is folded in so req_rdy drops the moment reset asserts.
  // A same-cycle return does not free a credit for a same-cycle grant.
  assign can_grant = rst_n && en && (outst < OUT_W'(MAX_OUTST));

  // Scan from ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_rdy   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!grant_any && req_vld[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (can_grant && grant_any) req_rdy[grant_idx] = 1'b1;
  end

  assign accept = can_grant && grant_any;
  // A return with nothing in flight is a protocol error and is dropped.
  assign ret_ok = sq_vld_out && (outst != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sq_vld_in <= 1'b0;
      sq_x      <= '0;
      rsp_vld   <= '0;
      rsp_y     <= '0;
      outst     <= '0;
      err       <= 1'b0;
    end else begin
      sq_vld_in <= accept;
      if (accept) begin
        sq_x   <= req_x[32*grant_idx +: 32];
        ptr    <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end

      rsp_vld <= ret_ok ? (N_REQ'(1) << id_mem[rd_ptr]) : '0;
      if (ret_ok) begin
        rsp_y  <= sq_y;
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (sq_vld_out && (outst == '0)) err <= 1'b1;

      if (accept && !ret_ok)      outst <= outst + 1'b1;
      else if (!accept && ret_ok) outst <= outst - 1'b1;
    end
  end

  // ID storage needs no reset: only entries between rd_ptr and wr_ptr are read.
  always_ff @(posedge clk) begin
    if (accept) id_mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_sqrt_arb.sv
module tb_sqrt_arb;
  localparam int N   = 4;
  localparam int MAX = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req_vld = '0;
  logic [N*32-1:0] req_x = '0;
  logic [N-1:0]   req_rdy;
  logic           sq_vld_in;
  logic [31:0]    sq_x;
  logic           sq_vld_out = 1'b0;
  logic [15:0]    sq_y = '0;
  logic [N-1:0]   rsp_vld;
  logic [15:0]    rsp_y;
  logic [5:0]     outst;
  logic           err;

  always #5 clk = ~clk;

  sqrt_arb #(.N_REQ(N), .MAX_OUTST(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_vld(req_vld), .req_x(req_x),
    .req_rdy(req_rdy), .sq_vld_in(sq_vld_in), .sq_x(sq_x),
    .sq_vld_out(sq_vld_out), .sq_y(sq_y), .rsp_vld(rsp_vld), .rsp_y(rsp_y),
    .outst(outst), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queues of requester ids and radicands in issue order.
  logic [31:0] x_in [N];
  int          id_q [$];
  logic [31:0] x_q [$];
  int          m_ptr = 0;
  logic        m_err = 1'b0;

  logic [N-1:0] exp_rdy, exp_rsp_vld, obs_rdy, obs_rsp_vld;
  logic         exp_sq_vld, obs_sq_vld, obs_err;
  logic [31:0]  exp_sq_x = '0, obs_sq_x;
  logic [15:0]  exp_rsp_y = '0, obs_rsp_y;
  logic [5:0]   obs_outst;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [63:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  task automatic sample();
    obs_sq_vld  = sq_vld_in;
    obs_sq_x    = sq_x;
    obs_rsp_vld = rsp_vld;
    obs_rsp_y   = rsp_y;
    obs_outst   = outst;
    obs_err     = err;
  endtask

  // One clock: drive inputs at the falling edge, predict, sample after the rising edge.
  task automatic step(input logic [N-1:0] vld, input logic e, input logic ret);
    int g;
    int r;
    @(negedge clk);
    for (int i = 0; i < N; i++) req_x[32*i +: 32] = x_in[i];
    req_vld    = vld;
    en         = e;
    sq_vld_out = ret;
    sq_y       = (x_q.size() > 0) ? isqrt(x_q[0]) : 16'($urandom);
    g = -1;
    if (e && id_q.size() < MAX)
      for (int k = 0; k < N; k++)
        if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1 obs_rdy = req_rdy;
    @(posedge clk);
    exp_rsp_vld = '0;
    if (ret) begin
      if (id_q.size() > 0) begin
        r = id_q.pop_front();
        exp_rsp_vld[r] = 1'b1;
        exp_rsp_y = isqrt(x_q.pop_front());
      end else begin
        m_err = 1'b1;
      end
    end
    exp_sq_vld = (g >= 0);
    if (g >= 0) begin
      id_q.push_back(g);
      x_q.push_back(x_in[g]);
      exp_sq_x = x_in[g];
      m_ptr = (g + 1) % N;
    end
    #1 sample();
  endtask

  // Reset pulse asserted mid-cycle with requests pending; outputs sampled while low.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req_vld = '1;
    en = 1'b1;
    sq_vld_out = 1'b0;
    #1;
    obs_rdy = req_rdy;
    sample();
    id_q.delete();
    x_q.delete();
    m_ptr = 0;
    m_err = 1'b0;
    exp_sq_x = '0;
    exp_rsp_y = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    req_vld = '0;
    en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (obs_rdy !== '0) begin n_bad++; $display("FAIL reset_rdy: got %b expected 0", obs_rdy); end
    n_cmp++; if (obs_sq_vld !== 1'b0) begin n_bad++; $display("FAIL reset_sq_vld: got %b expected 0", obs_sq_vld); end
    n_cmp++; if (obs_sq_x !== '0) begin n_bad++; $display("FAIL reset_sq_x: got %h expected 0", obs_sq_x); end
    n_cmp++; if (obs_rsp_vld !== '0) begin n_bad++; $display("FAIL reset_rsp_vld: got %b expected 0", obs_rsp_vld); end
    n_cmp++; if (obs_rsp_y !== '0) begin n_bad++; $display("FAIL reset_rsp_y: got %h expected 0", obs_rsp_y); end
    n_cmp++; if (obs_outst !== '0) begin n_bad++; $display("FAIL reset_outst: got %0d expected 0", obs_outst); end
    n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", obs_err); end
  endtask

  task automatic test_single();
    logic [31:0] xs [4];
    logic [15:0] ys [4];
    xs = '{32'h0000_0100, 32'h0000_00FF, 32'h8000_0000, 32'hFFFF_FFFF};
    ys = '{16'd16, 16'd15, 16'd46340, 16'd65535};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      x_in[0] = xs[i];
      step(4'b0001, 1'b1, 1'b0);
      n_cmp++; if (obs_rdy !== 4'b0001) begin n_bad++; $display("FAIL single_rdy[%0d]: got %b expected 0001", i, obs_rdy); end
      n_cmp++; if (obs_sq_vld !== 1'b1 || obs_sq_x !== xs[i]) begin n_bad++; $display("FAIL single_issue[%0d]: got vld=%b x=%h expected vld=1 x=%h", i, obs_sq_vld, obs_sq_x, xs[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 1'b1, 1'b1);
      n_cmp++; if (obs_rsp_vld !== 4'b0001 || obs_rsp_y !== ys[i]) begin n_bad++; $display("FAIL single_rsp[%0d]: got vld=%b y=%0d expected vld=0001 y=%0d", i, obs_rsp_vld, obs_rsp_y, ys[i]); end
    end
    step(4'b0000, 1'b1, 1'b0);
    n_cmp++; if (obs_rsp_vld !== '0 || obs_rsp_y !== 16'd65535 || obs_sq_vld !== 1'b0) begin n_bad++; $display("FAIL single_idle: got rsp_vld=%b y=%0d sq_vld=%b expected 0/65535/0", obs_rsp_vld, obs_rsp_y, obs_sq_vld); end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    do_reset();
    x_in = '{32'd4, 32'd9, 32'd16, 32'd25};
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      oh = 4'b0001 << i;
      n_cmp++; if (obs_rdy !== oh) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, obs_rdy, oh); end
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 1'b1, 1'b1);
      oh = 4'b0001 << i;
      n_cmp++; if (obs_rsp_vld !== oh || obs_rsp_y !== 16'(i + 2)) begin n_bad++; $display("FAIL rr_rsp[%0d]: got vld=%b y=%0d expected vld=%b y=%0d", i, obs_rsp_vld, obs_rsp_y, oh, i + 2); end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < MAX + 8 && id_q.size() < MAX; i++) begin
      x_in[0] = $urandom;
      step(4'b0001, 1'b1, 1'b0);
    end
    n_cmp++; if (obs_outst !== 6'(MAX)) begin n_bad++; $display("FAIL full_outst: got %0d expected %0d", obs_outst, MAX); end
    step(4'b0001, 1'b1, 1'b0);
    n_cmp++; if (obs_rdy !== '0) begin n_bad++; $display("FAIL full_rdy: got %b expected 0", obs_rdy); end
    step(4'b0001, 1'b1, 1'b1);
    n_cmp++; if (obs_rdy !== '0 || obs_outst !== 6'(MAX - 1)) begin n_bad++; $display("FAIL full_ret_same_cycle: got rdy=%b outst=%0d expected 0/%0d", obs_rdy, obs_outst, MAX - 1); end
    step(4'b0001, 1'b1, 1'b0);
    n_cmp++; if (obs_rdy !== 4'b0001 || obs_outst !== 6'(MAX)) begin n_bad++; $display("FAIL full_resume: got rdy=%b outst=%0d expected 0001/%0d", obs_rdy, obs_outst, MAX); end
    for (int i = 0; i < MAX + 8 && id_q.size() > 0; i++) begin
      step(4'b0000, 1'b1, 1'b1);
      n_cmp++; if (obs_rsp_vld !== exp_rsp_vld || obs_rsp_y !== exp_rsp_y) begin n_bad++; $display("FAIL full_drain[%0d]: got vld=%b y=%h expected vld=%b y=%h", i, obs_rsp_vld, obs_rsp_y, exp_rsp_vld, exp_rsp_y); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < N; i++) x_in[i] = $urandom;
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b0);
    n_cmp++; if (obs_outst !== 6'd5) begin n_bad++; $display("FAIL simul_pre_outst: got %0d expected 5", obs_outst); end
    step(4'b1111, 1'b1, 1'b1);
    n_cmp++; if (obs_outst !== 6'd5) begin n_bad++; $display("FAIL simul_outst: got %0d expected 5", obs_outst); end
    n_cmp++; if (obs_rsp_vld !== 4'b0001 || obs_rsp_y !== exp_rsp_y) begin n_bad++; $display("FAIL simul_rsp: got vld=%b y=%h expected vld=0001 y=%h", obs_rsp_vld, obs_rsp_y, exp_rsp_y); end
    n_cmp++; if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL simul_rdy: got %b expected %b", obs_rdy, exp_rdy); end
    for (int i = 0; i < 16 && id_q.size() > 0; i++) step(4'b0000, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic e, r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) x_in[i] = $urandom;
      v = N'($urandom);
      e = ($urandom_range(0, 3) != 0);
      r = (id_q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 63) == 0);
      step(v, e, r);
      n_cmp++; if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL rand_rdy[%0d]: got %b expected %b", c, obs_rdy, exp_rdy); end
      n_cmp++; if (obs_sq_vld !== exp_sq_vld || obs_sq_x !== exp_sq_x) begin n_bad++; $display("FAIL rand_issue[%0d]: got %b/%h expected %b/%h", c, obs_sq_vld, obs_sq_x, exp_sq_vld, exp_sq_x); end
      n_cmp++; if (obs_rsp_vld !== exp_rsp_vld || obs_rsp_y !== exp_rsp_y) begin n_bad++; $display("FAIL rand_rsp[%0d]: got %b/%h expected %b/%h", c, obs_rsp_vld, obs_rsp_y, exp_rsp_vld, exp_rsp_y); end
      n_cmp++; if (obs_outst !== 6'(id_q.size())) begin n_bad++; $display("FAIL rand_outst[%0d]: got %0d expected %0d", c, obs_outst, id_q.size()); end
      n_cmp++; if (obs_err !== m_err) begin n_bad++; $display("FAIL rand_err[%0d]: got %b expected %b", c, obs_err, m_err); end
    end
    for (int i = 0; i < MAX + 8 && id_q.size() > 0; i++) step(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_err();
    do_reset();
    step(4'b0000, 1'b1, 1'b1);
    n_cmp++; if (obs_err !== 1'b1 || obs_rsp_vld !== '0 || obs_outst !== '0) begin n_bad++; $display("FAIL err_set: got err=%b rsp_vld=%b outst=%0d expected 1/0/0", obs_err, obs_rsp_vld, obs_outst); end
    x_in[2] = 32'd49;
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    n_cmp++; if (obs_err !== 1'b1 || obs_rsp_vld !== 4'b0100 || obs_rsp_y !== 16'd7) begin n_bad++; $display("FAIL err_sticky: got err=%b rsp_vld=%b y=%0d expected 1/0100/7", obs_err, obs_rsp_vld, obs_rsp_y); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) x_in[i] = 32'd100 + 32'(i);
    for (int i = 0; i < 3; i++) step(4'b0111, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    n_cmp++; if (obs_outst !== 6'd2 || obs_rsp_y !== 16'd10) begin n_bad++; $display("FAIL mid_pre: got outst=%0d y=%0d expected 2/10", obs_outst, obs_rsp_y); end
    step(4'b0001, 1'b1, 1'b0);
    n_cmp++; if (obs_outst !== 6'd3) begin n_bad++; $display("FAIL mid_outst3: got %0d expected 3", obs_outst); end
    do_reset();
    n_cmp++; if (obs_rdy !== '0 || obs_sq_vld !== 1'b0 || obs_sq_x !== '0 || obs_rsp_vld !== '0 || obs_rsp_y !== '0 || obs_outst !== '0 || obs_err !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got rdy=%b sqv=%b sqx=%h rspv=%b y=%h outst=%0d err=%b expected all 0", obs_rdy, obs_sq_vld, obs_sq_x, obs_rsp_vld, obs_rsp_y, obs_outst, obs_err);
    end
    step(4'b1010, 1'b1, 1'b0);
    n_cmp++; if (obs_rdy !== 4'b0010) begin n_bad++; $display("FAIL mid_first_grant: got %b expected 0010", obs_rdy); end
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    n_cmp++; if (obs_err !== 1'b1 || obs_rsp_vld !== '0 || obs_outst !== '0) begin n_bad++; $display("FAIL mid_stale_return: got err=%b rsp_vld=%b outst=%0d expected 1/0/0", obs_err, obs_rsp_vld, obs_outst); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) x_in[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_simultaneous();
    test_random();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the end, got time limit expected completion");
    $fatal(1, "timeout");
  end

endmodule
